// File: rtl/csr_access_unit_if.sv
// Request/response bundle between the CSR-instruction issuer and csr_access_unit.
// The master drives a decoded Zicsr request and consumes the old-value response.
interface csr_access_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic            req_use_imm;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_rs1_data;
    logic [4:0]      req_zimm;
    logic            req_src_nz;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rd_data;
    logic            rsp_illegal;

    modport master (
        output req_valid, req_op, req_use_imm, req_addr, req_rs1_data, req_zimm, req_src_nz,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rd_data, rsp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_use_imm, req_addr, req_rs1_data, req_zimm, req_src_nz,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rd_data, rsp_illegal
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: read the CSR, issue one read-modify-write strobe, return the old value.
// One request in flight at a time; stall is held for the whole READ/EXEC/RESP sequence.
module csr_access_unit #(
    parameter int XLEN     = 32,
    parameter bit RO_CHECK = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    csr_access_unit_if.slave req,
    output logic [11:0]      csr_adr_rd,
    input  logic [XLEN-1:0]  csr_rddata,
    output logic [11:0]      csr_adr_wr,
    output logic [XLEN-1:0]  csr_wrdata,
    output logic             csr_wr_en,
    output logic             stall
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q;
    logic            src_nz_q;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            ill_q, ill_d;
    logic [11:0]     wadr_q, wadr_d;
    logic [XLEN-1:0] wdat_q, wdat_d;
    logic            wr_en;
    logic            ro_space;
    logic            intent;
    logic            wr_ok;
    logic            ill_now;

    function automatic logic [XLEN-1:0] merge_wdata(input logic [1:0] op,
                                                    input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] src);
        case (op)
            2'b10:   return old | src;
            2'b11:   return old & ~src;
            default: return src;
        endcase
    endfunction

    // RS/RC without a nonzero source are pure reads, even in read-only space.
    assign ro_space = RO_CHECK && (addr_q[11:10] == 2'b11);
    assign intent   = (op_q == 2'b01) || ((op_q != 2'b00) && src_nz_q);
    assign wr_ok    = intent && !ro_space;
    assign ill_now  = (op_q == 2'b00) || (ro_space && intent);

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        ill_d   = ill_q;
        wadr_d  = wadr_q;
        wdat_d  = wdat_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: if (req.req_valid) state_d = READ;
            // The CSR file only refreshes csr_rddata on non-freeze edges.
            READ: if (!freeze) state_d = EXEC;
            EXEC: begin
                rd_d  = csr_rddata;
                ill_d = ill_now;
                wr_en = wr_ok;
                if (wr_ok) begin
                    wadr_d = addr_q;
                    wdat_d = merge_wdata(op_q, csr_rddata, src_q);
                end
                state_d = RESP;
            end
            RESP: if (req.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            addr_q   <= 12'h000;
            src_q    <= '0;
            src_nz_q <= 1'b0;
            rd_q     <= '0;
            ill_q    <= 1'b0;
            wadr_q   <= 12'h000;
            wdat_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            ill_q   <= ill_d;
            wadr_q  <= wadr_d;
            wdat_q  <= wdat_d;
            if (state_q == IDLE && req.req_valid) begin
                op_q     <= req.req_op;
                addr_q   <= req.req_addr;
                src_q    <= req.req_use_imm ? {{(XLEN-5){1'b0}}, req.req_zimm} : req.req_rs1_data;
                src_nz_q <= req.req_src_nz;
            end
        end
    end

    // Write port passes the EXEC value through combinationally and holds it afterwards.
    assign csr_adr_wr      = wadr_d;
    assign csr_wrdata      = wdat_d;
    assign csr_wr_en       = wr_en;
    assign csr_adr_rd      = addr_q;
    assign stall           = (state_q != IDLE);
    assign req.req_ready   = (state_q == IDLE);
    assign req.rsp_valid   = (state_q == RESP);
    assign req.rsp_rd_data = rd_q;
    assign req.rsp_illegal = ill_q;
endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: behavioural CSR file plus an ISA-level reference of Zicsr semantics.
module tb_csr_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic [11:0] csr_adr_rd;
    logic [31:0] csr_rddata = 32'h0;
    logic [11:0] csr_adr_wr;
    logic [31:0] csr_wrdata;
    logic        csr_wr_en;
    logic        stall;

    csr_access_unit_if #(.XLEN(32)) bus ();

    csr_access_unit #(.XLEN(32), .RO_CHECK(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freeze     (freeze),
        .req        (bus),
        .csr_adr_rd (csr_adr_rd),
        .csr_rddata (csr_rddata),
        .csr_adr_wr (csr_adr_wr),
        .csr_wrdata (csr_wrdata),
        .csr_wr_en  (csr_wr_en),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    bit [31:0]   csr_mem [4096];
    bit [31:0]   ref_mem [4096];
    int          wr_cnt = 0;
    logic        poke_en = 1'b0;
    logic [11:0] poke_adr = 12'h0;
    logic [31:0] poke_dat = 32'h0;
    logic [31:0] last_w = 32'h0;
    int          total = 0;
    int          bad = 0;

    // Behavioural CSR file: registered read data updated only on non-freeze edges.
    always @(posedge clk) begin
        if (!freeze) csr_rddata <= csr_mem[csr_adr_rd];
        if (csr_wr_en) begin
            csr_mem[csr_adr_wr] <= csr_wrdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (poke_en) csr_mem[poke_adr] <= poke_dat;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_adr = a; poke_dat = v;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic do_req(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] zimm, input logic nz,
                          input int frz, input int hold);
        logic [31:0] src, old, nv;
        logic        intent, ro, ill, wr;
        int          wc0;
        src    = imm ? {27'b0, zimm} : rs1;
        old    = ref_mem[addr];
        intent = (op == 2'b01) || (op != 2'b00 && nz);
        ro     = (addr[11:10] == 2'b11);
        ill    = (op == 2'b00) || (ro && intent);
        wr     = intent && !ro;
        case (op)
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = old;
        endcase
        if (wr) begin
            ref_mem[addr] = nv;
            last_w = nv;
        end
        wc0 = wr_cnt;

        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_use_imm = imm; bus.req_addr = addr;
        bus.req_rs1_data = rs1; bus.req_zimm = zimm; bus.req_src_nz = nz;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("stall_read", 32'(stall), 32'd1);
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        chk("adr_rd", 32'(csr_adr_rd), 32'(addr));
        freeze = (frz > 0);
        repeat (frz) begin
            @(negedge clk);
            chk("frz_no_wr", 32'(csr_wr_en), 32'd0);
            chk("frz_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        freeze = 1'b0;
        @(negedge clk);
        chk("exec_wr_en", 32'(csr_wr_en), 32'(wr));
        if (wr) begin
            chk("exec_adr_wr", 32'(csr_adr_wr), 32'(addr));
            chk("exec_wrdata", csr_wrdata, nv);
        end
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_rd", bus.rsp_rd_data, old);
        chk("rsp_ill", 32'(bus.rsp_illegal), 32'(ill));
        if (hold > 0) bus.rsp_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rd", bus.rsp_rd_data, old);
            chk("hold_ill", 32'(bus.rsp_illegal), 32'(ill));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("done_valid", 32'(bus.rsp_valid), 32'd0);
        chk("done_req_ready", 32'(bus.req_ready), 32'd1);
        chk("strobe_count", 32'(wr_cnt - wc0), 32'(wr));
        chk("csr_state", csr_mem[addr], ref_mem[addr]);
        chk("wrdata_hold", csr_wrdata, last_w);
    endtask

    logic [11:0] addrs [8];

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_use_imm = 1'b0; bus.req_addr = 12'h0;
        bus.req_rs1_data = 32'h0; bus.req_zimm = 5'h0; bus.req_src_nz = 1'b0; bus.rsp_ready = 1'b1;
        addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h305; addrs[3] = 12'h340;
        addrs[4] = 12'h341; addrs[5] = 12'hF11; addrs[6] = 12'hF14; addrs[7] = 12'hC00;

        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wr_en", 32'(csr_wr_en), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_wrdata", csr_wrdata, 32'd0);
        chk("rst_adr_wr", 32'(csr_adr_wr), 32'd0);
        chk("rst_adr_rd", 32'(csr_adr_rd), 32'd0);
        chk("rst_rd_data", bus.rsp_rd_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // T1 RW on mtvec
        poke(12'h305, 32'h100);
        do_req(2'b01, 1'b0, 12'h305, 32'h204, 5'd0, 1'b1, 0, 0);
        // T2 set then clear on mie
        poke(12'h304, 32'h0);
        do_req(2'b10, 1'b0, 12'h304, 32'h80, 5'd0, 1'b1, 0, 0);
        do_req(2'b11, 1'b0, 12'h304, 32'h80, 5'd0, 1'b1, 0, 0);
        // T3 RS with no write intent on mstatus
        poke(12'h300, 32'h1888);
        do_req(2'b10, 1'b0, 12'h300, 32'hFFFF, 5'd0, 1'b0, 0, 0);
        // T4 read-only space
        poke(12'hF14, 32'h0);
        do_req(2'b01, 1'b0, 12'hF14, 32'h55, 5'd0, 1'b1, 0, 0);
        do_req(2'b10, 1'b0, 12'hF14, 32'h0, 5'd0, 1'b0, 0, 0);
        // Reserved op and immediate form
        do_req(2'b00, 1'b0, 12'h340, 32'h77, 5'd0, 1'b1, 0, 0);
        do_req(2'b10, 1'b1, 12'h340, 32'hDEAD_BEEF, 5'h15, 1'b1, 0, 0);
        // T5 freeze in READ, T6 response back-pressure
        poke(12'h341, 32'hCAFE_0000);
        do_req(2'b01, 1'b0, 12'h341, 32'h1234_5678, 5'd0, 1'b1, 3, 0);
        do_req(2'b11, 1'b1, 12'h341, 32'h0, 5'h1F, 1'b1, 0, 5);

        for (int i = 0; i < 8; i++) poke(addrs[i], $urandom);
        for (int i = 0; i < 40; i++) begin
            logic [4:0] z;
            logic       imm;
            z   = 5'($urandom_range(0, 31));
            imm = 1'($urandom_range(0, 1));
            do_req(2'($urandom_range(0, 3)), imm, addrs[$urandom_range(0, 7)], $urandom, z,
                   imm ? (z != 5'd0) : 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // T6 reset while in READ: aborts with no strobe and no response
        begin
            int wc0;
            wc0 = wr_cnt;
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_use_imm = 1'b0;
            bus.req_addr = 12'h305; bus.req_rs1_data = 32'hBAD0_BAD0; bus.req_src_nz = 1'b1;
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk("abort_in_read", 32'(stall), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
            chk("abort_stall", 32'(stall), 32'd0);
            chk("abort_wrdata", csr_wrdata, 32'd0);
            chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            last_w = 32'h0;
            repeat (4) begin
                @(negedge clk);
                chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
            end
            chk("abort_no_strobe", 32'(wr_cnt - wc0), 32'd0);
            chk("abort_csr_kept", csr_mem[12'h305], ref_mem[12'h305]);
        end
        do_req(2'b10, 1'b0, 12'h305, 32'h3, 5'd0, 1'b1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
